// File: rtl/ad_pkg.sv
// ---------------------------------------------------------------------------
// ad_pkg : shared constants, FSM encodings and width helper for ad_frame_pack
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ad_pkg;

  localparam logic [15:0] MAGIC_WORD = 16'hA55A;
  localparam int          HDR_WORDS  = 3;

  localparam logic [1:0] F_IDLE  = 2'd0;
  localparam logic [1:0] F_FILL  = 2'd1;
  localparam logic [1:0] F_STALL = 2'd2;

  localparam logic [2:0] D_IDLE = 3'd0;
  localparam logic [2:0] D_H0   = 3'd1;
  localparam logic [2:0] D_H1   = 3'd2;
  localparam logic [2:0] D_H2   = 3'd3;
  localparam logic [2:0] D_PAY  = 3'd4;

  function automatic int odsize(input int dsize);
    return 2 * dsize;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ad_pp_ram.sv
// ---------------------------------------------------------------------------
// ad_pp_ram : two-bank ping-pong simple dual-port RAM, address {bank, idx}
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ad_pp_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             i_ad_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // Depth covers the full {bank, idx} space so non-power-of-two frames still map.
  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge i_ad_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

`default_nettype wire

// File: rtl/ad_frame_pack.sv
// ---------------------------------------------------------------------------
// ad_frame_pack : groups A/D dual-sample words into framed valid/ready stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ad_frame_pack
  import ad_pkg::*;
#(
  parameter int          DSIZE       = 8,
  parameter int          FRAME_WORDS = 64,
  parameter logic [15:0] MAGIC       = MAGIC_WORD
) (
  input  logic                       i_ad_clk,
  input  logic                       i_rst_n,
  input  logic [odsize(DSIZE)-1:0]   i_dual_data,
  input  logic                       i_data_on,
  input  logic                       i_working,
  output logic [odsize(DSIZE)-1:0]   o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_sop,
  output logic                       o_eop,
  output logic                       o_overflow,
  output logic [15:0]                o_drop_cnt
);

  localparam int ODSIZE = odsize(DSIZE);
  localparam int c_wcw  = $clog2(FRAME_WORDS + 1);
  localparam int c_iw   = $clog2(FRAME_WORDS);
  localparam logic [c_wcw-1:0] c_frame_len = c_wcw'(FRAME_WORDS);
  localparam logic [c_wcw-1:0] c_one       = c_wcw'(1);

  logic [1:0]       r_fstate;
  logic             r_wsel;
  logic [c_wcw-1:0] r_wcnt;
  logic [2:0]       r_dstate;
  logic             r_rsel;
  logic [c_wcw-1:0] r_rcnt;
  logic [1:0]       r_full;
  logic [1:0]       r_full_q;
  logic [c_wcw-1:0] r_len [2];
  logic [15:0]      r_seq;
  logic [15:0]      r_drop_cnt;
  logic             r_overflow;

  logic             w_wr;
  logic [c_wcw-1:0] w_wcnt_nxt;
  logic             w_close;
  logic             w_discard;
  logic [c_wcw-1:0] w_cur_len;
  logic [c_wcw-1:0] w_last_idx;
  logic             w_last;
  logic             w_free_ev;
  logic             w_free_wsel;
  logic             w_free_other;
  logic [1:0]       w_set_mask;
  logic [1:0]       w_free_mask;
  logic             w_re;
  logic [c_iw-1:0]  w_ridx;
  logic [ODSIZE-1:0] w_rdata;

  assign w_wr       = (r_fstate == F_FILL) && i_working && i_data_on;
  assign w_wcnt_nxt = w_wr ? (r_wcnt + c_one) : r_wcnt;
  assign w_close    = (r_fstate == F_FILL) &&
                      ((w_wcnt_nxt == c_frame_len) || (!i_working && (r_wcnt != '0)));
  assign w_discard  = (r_fstate == F_FILL) && !i_working && (r_wcnt == '0);

  assign w_cur_len  = r_len[r_rsel];
  assign w_last_idx = w_cur_len - c_one;
  assign w_last     = (r_rcnt == w_last_idx);
  assign w_free_ev  = (r_dstate == D_PAY) && i_ready && w_last;

  // Bank-free lookahead lets a close and a same-edge free skip the stall.
  assign w_free_wsel  = !r_full[r_wsel]  || (w_free_ev && (r_rsel == r_wsel));
  assign w_free_other = !r_full[~r_wsel] || (w_free_ev && (r_rsel != r_wsel));

  assign w_set_mask  = w_close   ? (r_wsel ? 2'b10 : 2'b01) : 2'b00;
  assign w_free_mask = w_free_ev ? (r_rsel ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fstate   <= F_IDLE;
      r_wsel     <= 1'b0;
      r_wcnt     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      case (r_fstate)
        F_IDLE: if (i_working && w_free_wsel) r_fstate <= F_FILL;
        F_FILL: begin
          if (w_close) begin
            r_wsel   <= ~r_wsel;
            r_wcnt   <= '0;
            r_fstate <= w_free_other ? F_FILL : F_STALL;
          end else if (w_discard) begin
            r_fstate <= F_IDLE;
          end else begin
            r_wcnt <= w_wcnt_nxt;
          end
        end
        F_STALL: begin
          if (!i_working)                              r_fstate <= F_IDLE;
          else if (w_free_ev && (r_rsel == r_wsel))    r_fstate <= F_FILL;
        end
        default: r_fstate <= F_IDLE;
      endcase
      if ((r_fstate == F_STALL) && i_data_on) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // The drain watches a one-cycle-late copy of the full flags, so a header
  // launches two clocks after its frame closes.
  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full   <= '0;
      r_full_q <= '0;
      r_len[0] <= '0;
      r_len[1] <= '0;
    end else begin
      r_full   <= (r_full | w_set_mask) & ~w_free_mask;
      r_full_q <= r_full & ~w_free_mask;
      if (w_close) r_len[r_wsel] <= w_wcnt_nxt;
    end
  end

  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dstate <= D_IDLE;
      r_rsel   <= 1'b0;
      r_rcnt   <= '0;
      r_seq    <= '0;
    end else begin
      case (r_dstate)
        D_IDLE: if (r_full_q[r_rsel]) r_dstate <= D_H0;
        D_H0:   if (i_ready) r_dstate <= D_H1;
        D_H1:   if (i_ready) r_dstate <= D_H2;
        D_H2: begin
          if (i_ready) begin
            r_dstate <= D_PAY;
            r_rcnt   <= '0;
          end
        end
        D_PAY: begin
          if (i_ready) begin
            if (w_last) begin
              r_rsel   <= ~r_rsel;
              r_seq    <= r_seq + 16'd1;
              r_rcnt   <= '0;
              r_dstate <= r_full_q[~r_rsel] ? D_H0 : D_IDLE;
            end else begin
              r_rcnt <= r_rcnt + c_one;
            end
          end
        end
        default: r_dstate <= D_IDLE;
      endcase
    end
  end

  // Payload word 0 is fetched on the len transfer; later words one ahead.
  assign w_re   = i_ready && ((r_dstate == D_H2) || ((r_dstate == D_PAY) && !w_last));
  assign w_ridx = (r_dstate == D_H2) ? '0 : c_iw'(r_rcnt + c_one);

  ad_pp_ram #(
    .WIDTH (ODSIZE),
    .AW    (c_iw + 1)
  ) u_ram (
    .i_ad_clk (i_ad_clk),
    .i_we     (w_wr),
    .i_waddr  ({r_wsel, r_wcnt[c_iw-1:0]}),
    .i_wdata  (i_dual_data),
    .i_re     (w_re),
    .i_raddr  ({r_rsel, w_ridx}),
    .o_rdata  (w_rdata)
  );

  always_comb begin
    o_data = '0;
    case (r_dstate)
      D_H0:    o_data = ODSIZE'(MAGIC);
      D_H1:    o_data = ODSIZE'(r_seq);
      D_H2:    o_data = ODSIZE'(w_cur_len);
      D_PAY:   o_data = w_rdata;
      default: o_data = '0;
    endcase
  end

  assign o_valid    = (r_dstate != D_IDLE);
  assign o_sop      = (r_dstate == D_H0);
  assign o_eop      = (r_dstate == D_PAY) && w_last;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ad_frame_pack.sv
// ---------------------------------------------------------------------------
// tb_ad_frame_pack : directed self-checking bench for ad_frame_pack (4-word frames)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ad_frame_pack;

  localparam int DSIZE = 8;
  localparam int FW    = 4;

  logic        i_ad_clk;
  logic        i_rst_n;
  logic [15:0] i_dual_data;
  logic        i_data_on;
  logic        i_working;
  logic [15:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_sop;
  logic        o_eop;
  logic        o_overflow;
  logic [15:0] o_drop_cnt;

  ad_frame_pack #(
    .DSIZE       (DSIZE),
    .FRAME_WORDS (FW),
    .MAGIC       (16'hA55A)
  ) dut (
    .i_ad_clk    (i_ad_clk),
    .i_rst_n     (i_rst_n),
    .i_dual_data (i_dual_data),
    .i_data_on   (i_data_on),
    .i_working   (i_working),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sop       (o_sop),
    .o_eop       (o_eop),
    .o_overflow  (o_overflow),
    .o_drop_cnt  (o_drop_cnt)
  );

  initial i_ad_clk = 1'b0;
  always #5 i_ad_clk = ~i_ad_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ready_mode = 0;
  int first_valid_cyc = -1;
  int t_w = 0;
  logic        prev_stall = 1'b0;
  logic [18:0] prev_word  = '0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];

  always @(posedge i_ad_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge i_ad_clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d);
    i_dual_data = d;
    i_data_on   = 1'b1;
    tick();
    t_w = cyc;
    i_data_on = 1'b0;
    tick();
  endtask

  task automatic exp_frame(input logic [15:0] seq, input int len, input logic [15:0] base);
    exp_q.push_back({2'b10, 16'hA55A});
    exp_q.push_back({2'b00, seq});
    exp_q.push_back({2'b00, 16'(len)});
    for (int i = 0; i < len; i++)
      exp_q.push_back({1'b0, (i == len - 1), base + 16'(i)});
  endtask

  task automatic drain_and_compare(input string tag, input int budget);
    int k = 0;
    while ((got_q.size() < exp_q.size()) && (k < budget)) begin
      tick();
      k++;
    end
    repeat (6) tick();
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Sink monitor: records transfers and checks hold-while-stalled.
  initial begin
    forever begin
      @(negedge i_ad_clk);
      if (!i_rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("hold", {o_valid, o_sop, o_eop, o_data}, prev_word);
        if (o_valid && i_ready) got_q.push_back({o_sop, o_eop, o_data});
        if (o_valid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
        prev_stall = o_valid && !i_ready;
        prev_word  = {o_valid, o_sop, o_eop, o_data};
      end
    end
  end

  initial begin
    int pat = 0;
    i_ready = 1'b0;
    forever begin
      @(posedge i_ad_clk);
      #1;
      case (ready_mode)
        1: begin
          i_ready = ((pat % 3) == 0);
          pat++;
        end
        2:       i_ready = 1'b0;
        default: i_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int k;
    i_rst_n     = 1'b0;
    i_working   = 1'b0;
    i_data_on   = 1'b0;
    i_dual_data = '0;
    repeat (3) tick();
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_sop_eop", {o_sop, o_eop}, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_drop", o_drop_cnt, 0);
    i_rst_n = 1'b1;
    tick();

    // 1: two full frames, alternating-clock input
    first_valid_cyc = -1;
    i_working = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      send_word(16'h00A0 + 16'(i));
      if (i == 3) k = t_w;
    end
    i_working = 1'b0;
    exp_frame(16'h0000, 4, 16'h00A0);
    exp_frame(16'h0001, 4, 16'h00A4);
    drain_and_compare("t1_word", 100);
    check("t1_latency", first_valid_cyc - k, 2);

    // 2: short frame, then an empty window
    i_working = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send_word(16'h00B0 + 16'(i));
    i_working = 1'b0;
    exp_frame(16'h0002, 3, 16'h00B0);
    drain_and_compare("t2_word", 100);
    i_working = 1'b1;
    repeat (4) tick();
    i_working = 1'b0;
    repeat (10) tick();
    check("t2_empty_win", got_q.size(), 0);

    // 3: sink back-pressure pattern 1,0,0,...
    ready_mode = 1;
    i_working  = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_word(16'h00C0 + 16'(i));
    i_working = 1'b0;
    exp_frame(16'h0003, 4, 16'h00C0);
    drain_and_compare("t3_word", 200);
    ready_mode = 0;
    tick();

    // 4: sink blocked for three frames of input
    ready_mode = 2;
    repeat (2) tick();
    i_working = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) send_word(16'h00D0 + 16'(i));
    i_working = 1'b0;
    repeat (3) tick();
    check("t4_overflow", o_overflow, 1);
    check("t4_drop_cnt", o_drop_cnt, 4);
    check("t4_stalled_hdr", {o_valid, o_sop, o_data}, {2'b11, 16'hA55A});
    ready_mode = 0;
    exp_frame(16'h0004, 4, 16'h00D0);
    exp_frame(16'h0005, 4, 16'h00D4);
    drain_and_compare("t4_word", 100);
    check("t4_drop_kept", o_drop_cnt, 4);

    // 5: sequence wrap
    force dut.r_seq = 16'hFFFF;
    tick();
    release dut.r_seq;
    i_working = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send_word(16'h00E0 + 16'(i));
    i_working = 1'b0;
    exp_frame(16'hFFFF, 4, 16'h00E0);
    exp_frame(16'h0000, 4, 16'h00E4);
    drain_and_compare("t5_word", 100);

    // 6: reset in the middle of a payload
    i_working = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_word(16'h00F0 + 16'(i));
    k = 0;
    while ((got_q.size() < 4) && (k < 50)) begin
      tick();
      k++;
    end
    check("t6_reach_pay", (got_q.size() >= 4), 1);
    i_working = 1'b0;
    i_rst_n   = 1'b0;
    #1;
    check("t6_rst_valid", o_valid, 0);
    check("t6_rst_data", o_data, 0);
    check("t6_rst_flags", {o_sop, o_eop, o_overflow}, 0);
    check("t6_rst_drop", o_drop_cnt, 0);
    got_q.delete();
    exp_q.delete();
    repeat (3) tick();
    i_rst_n = 1'b1;
    repeat (8) tick();
    check("t6_no_stale", got_q.size(), 0);
    i_working = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_word(16'h0100 + 16'(i));
    i_working = 1'b0;
    exp_frame(16'h0000, 4, 16'h0100);
    drain_and_compare("t6_word", 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
